// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU effective address, performs one load or store
// on a req/ready memory port, and returns extended load data or a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        is_store_reg, is_store_next;
  logic [1:0]  off_reg, off_next;
  logic [1:0]  cause_reg, cause_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] load_data_reg, load_data_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  // Store data replicated onto every byte lane according to access size
  logic [31:0] wdata_rep;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] =
        (funct3[1:0] == 2'b00) ? store_data[7:0] :
        (funct3[1:0] == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                 store_data[8*gi +: 8];
    end
  endgenerate

  // Read word shifted so the addressed byte sits in bits [7:0]
  logic [31:0] rdata_shifted;
  assign rdata_shifted = mem_rdata >> {off_reg, 3'b000};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      funct3_reg    <= 3'b000;
      is_store_reg  <= 1'b0;
      off_reg       <= 2'b00;
      cause_reg     <= CAUSE_NONE;
      cnt_reg       <= 8'd0;
      load_data_reg <= 32'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wstrb_reg <= 4'b0000;
      mem_wdata_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      funct3_reg    <= funct3_next;
      is_store_reg  <= is_store_next;
      off_reg       <= off_next;
      cause_reg     <= cause_next;
      cnt_reg       <= cnt_next;
      load_data_reg <= load_data_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wstrb_reg <= mem_wstrb_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Next-state logic: validate and launch, wait for memory, report
  always_comb begin
    state_next     = state_reg;
    funct3_next    = funct3_reg;
    is_store_next  = is_store_reg;
    off_next       = off_reg;
    cause_next     = cause_reg;
    cnt_next       = cnt_reg;
    load_data_next = load_data_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wstrb_next = mem_wstrb_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          funct3_next   = funct3;
          is_store_next = is_store;
          off_next      = addr[1:0];
          if (is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                       : (funct3 == 3'b011 || funct3[2:1] == 2'b11)) begin
            cause_next = CAUSE_ILLEGAL;
            state_next = RESP;
          end else if ((funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
            cause_next = CAUSE_MISALIGN;
            state_next = RESP;
          end else begin
            cause_next     = CAUSE_NONE;
            cnt_next       = 8'd0;
            mem_req_next   = 1'b1;
            mem_we_next    = is_store;
            mem_addr_next  = {addr[31:2], 2'b00};
            mem_wdata_next = wdata_rep;
            if (!is_store)
              mem_wstrb_next = 4'b0000;
            else if (funct3[1:0] == 2'b00)
              mem_wstrb_next = 4'b0001 << addr[1:0];
            else if (funct3[1:0] == 2'b01)
              mem_wstrb_next = 4'b0011 << addr[1:0];
            else
              mem_wstrb_next = 4'b1111;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_req_next = 1'b0;
          state_next   = RESP;
          if (!is_store_reg) begin
            case (funct3_reg)
              3'b000:  load_data_next = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
              3'b100:  load_data_next = {24'd0, rdata_shifted[7:0]};
              3'b001:  load_data_next = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
              3'b101:  load_data_next = {16'd0, rdata_shifted[15:0]};
              default: load_data_next = mem_rdata;
            endcase
          end
        end else if (cnt_reg == CNT_LAST) begin
          mem_req_next = 1'b0;
          cause_next   = CAUSE_TIMEOUT;
          state_next   = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        cause_next = CAUSE_NONE;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == RESP);
  assign fault       = (state_reg == RESP) && (cause_reg != CAUSE_NONE);
  assign fault_cause = (state_reg == RESP) ? cause_reg : CAUSE_NONE;
  assign load_data   = load_data_reg;
  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wstrb   = mem_wstrb_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses,
// a monitor pops and compares on done and on memory handshakes.
module tb_load_store_unit;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, fault, mem_req, mem_we, mem_ready;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          flt;
    logic [1:0]  cause;
    logic [31:0] ldata;
    bit          chk_lat;
    int          lat;
    int          start_cyc;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } memx_t;

  resp_t rq[$];
  memx_t mq[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] last_load;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference rules written directly from the RV32I size/sign definitions
  function automatic int acc_size(logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_legal(bit st, logic [2:0] f3);
    if (st) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] rd, int off);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    case (f3)
      3'd0: return 32'($signed(b[off]));
      3'd4: return 32'(b[off]);
      3'd1: begin h = {b[off+1], b[off]}; return 32'($signed(h)); end
      3'd5: begin h = {b[off+1], b[off]}; return 32'(h); end
      default: return rd;
    endcase
  endfunction

  task automatic do_txn(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                        logic [31:0] rd, int w);
    resp_t r;
    memx_t m;
    int k, sz, off;
    bit good;
    k = 0;
    while (busy && k < 100) begin @(posedge clk); #1; k++; end
    chk("idle_wait", 32'(busy), 32'd0);
    sz   = acc_size(f3);
    off  = int'(a[1:0]);
    good = is_legal(st, f3) && (off % sz == 0);
    r.start_cyc = cyc;
    r.chk_lat   = good;
    if (!is_legal(st, f3))      begin r.flt = 1; r.cause = 2'b10; r.lat = 0; end
    else if (off % sz != 0)     begin r.flt = 1; r.cause = 2'b01; r.lat = 0; end
    else if (w >= T)            begin r.flt = 1; r.cause = 2'b11; r.lat = 1 + T; end
    else begin
      r.flt = 0; r.cause = 2'b00; r.lat = 2 + w;
      if (!st) last_load = model_load(f3, rd, off);
    end
    r.ldata = last_load;
    rq.push_back(r);
    if (good) begin
      m.a  = {a[31:2], 2'b00};
      m.we = st;
      m.strb = 4'b0000;
      m.wd = 32'd0;
      for (int j = 0; j < 4; j++) begin
        if (st && j >= off && j < off + sz) m.strb[j] = 1'b1;
        m.wd[8*j +: 8] = sd[8*(j % sz) +: 8];
      end
      if (w < T) mq.push_back(m);
    end
    start = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    start = 0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (!good) begin
      chk("no_req_on_fault", 32'(mem_req), 32'd0);
    end else if (w >= T) begin
      repeat (T) begin @(posedge clk); #1; end
    end else begin
      repeat (w) begin mem_rdata = $urandom; @(posedge clk); #1; end
      mem_ready = 1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = $urandom;
    end
  endtask

  // Monitor: compares every done and every accepted memory request
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_done actual=1 expected=0");
        end else begin
          resp_t r;
          r = rq.pop_front();
          chk("fault", 32'(fault), 32'(r.flt));
          chk("fault_cause", 32'(fault_cause), 32'(r.cause));
          chk("load_data", load_data, r.ldata);
          if (r.chk_lat) chk("latency", 32'(cyc - r.start_cyc), 32'(r.lat));
          else if (cyc - r.start_cyc < 1 || cyc - r.start_cyc > 2)
            chk("fault_latency", 32'(cyc - r.start_cyc), 32'd1);
          $display("txn done cyc=%0d fault=%0d cause=%0d load_data=%h", cyc, fault,
                   fault_cause, load_data);
        end
      end else begin
        chk("fault_idle", {30'd0, fault_cause} | 32'(fault), 32'd0);
      end
      if (mem_req && mem_ready) begin
        if (mq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_req actual=1 expected=0");
        end else begin
          memx_t m;
          m = mq.pop_front();
          chk("mem_addr", mem_addr, m.a);
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
          if (m.we) chk("mem_wdata", mem_wdata, m.wd);
        end
      end
    end
  end

  initial begin
    logic [2:0] legal_ld [5];
    bit st;
    logic [2:0] f3;
    int w;
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_ready = 0; mem_rdata = 0; last_load = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cause", 32'(fault_cause), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // Directed cases
    do_txn(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_txn(0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0);
    do_txn(0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0);
    do_txn(1, 3'd1, 32'h22, 32'h1234ABCD, 32'h0, 3);
    do_txn(0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    do_txn(1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
    do_txn(1, 3'd0, 32'h201, 32'hCAFEF00D, 32'h0, 1);
    do_txn(0, 3'd2, 32'h300, 32'h0, 32'h0, T);
    chk("timeout_req_drop", 32'(mem_req), 0);
    do_txn(0, 3'd2, 32'h304, 32'h0, 32'h5555AAAA, 0);

    // Reset during ACCESS, then a late ready that must be ignored
    begin
      int k;
      k = 0;
      while (busy && k < 100) begin @(posedge clk); #1; k++; end
      start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h400;
      @(posedge clk); #1 start = 0;
      chk("abort_req_high", 32'(mem_req), 1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      last_load = 0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_req", 32'(mem_req), 0);
      chk("abort_load_data", load_data, 0);
      mem_ready = 1; mem_rdata = 32'h12345678;
      @(posedge clk); #1 mem_ready = 0;
      repeat (3) @(posedge clk);
      #1 chk("abort_idle", 32'(busy), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = legal_ld[$urandom_range(0, 4)];
      w = ($urandom_range(0, 14) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 4);
      do_txn(st, f3, $urandom, $urandom, $urandom, w);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(rq.size()), 0);
    chk("mem_queue_empty", 32'(mq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
